// File: rtl/axil_driver_pkg.sv
// Shared types and constants for the AXI4-Lite command-driven bus master.
package axil_driver_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WRESP,
      ST_RADDR,
      ST_RDATA,
      ST_DONE
   } state_e;

endpackage

// File: rtl/axil_driver_master_io_sync.sv
// Two-flop synchronizer for asynchronous inputs with a rising-edge pulse on the synchronized value.
module io_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rise_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/axil_driver_master.sv
// AXI4-Lite master: one single-beat command in, one AXI transaction out, one response pulse back.
// Also hosts a GPIO output register and a synchronized GPIO input block.
module axil_driver_master
   import axil_driver_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int NUMB_INPUT_IO  = 1,
   parameter int NUMB_OUTPUT_IO = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      aclk,
   input  logic                      aclk_reset_n,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   output logic                      rsp_write,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      rsp_timeout,
   output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
   output logic [2:0]                m_axil_awprot,
   output logic                      m_axil_awvalid,
   input  logic                      m_axil_awready,
   output logic [DATA_WIDTH-1:0]     m_axil_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
   output logic                      m_axil_wvalid,
   input  logic                      m_axil_wready,
   input  logic [1:0]                m_axil_bresp,
   input  logic                      m_axil_bvalid,
   output logic                      m_axil_bready,
   output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
   output logic [2:0]                m_axil_arprot,
   output logic                      m_axil_arvalid,
   input  logic                      m_axil_arready,
   input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
   input  logic [1:0]                m_axil_rresp,
   input  logic                      m_axil_rvalid,
   output logic                      m_axil_rready,
   input  logic                      gpio_wr_en,
   input  logic [NUMB_OUTPUT_IO-1:0] gpio_wr_data,
   output logic [NUMB_OUTPUT_IO-1:0] gpio_out,
   input  logic [NUMB_INPUT_IO-1:0]  gpio_in,
   output logic [NUMB_INPUT_IO-1:0]  gpio_in_sync,
   output logic [NUMB_INPUT_IO-1:0]  gpio_in_rise
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_e                    state_q, state_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0]         wstrb_q, wstrb_d;
   logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic                      arvalid_q, arvalid_d, rready_q, rready_d;
   logic                      rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
   logic                      rsp_timeout_q, rsp_timeout_d;
   logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic [1:0]                rsp_resp_q, rsp_resp_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [NUMB_OUTPUT_IO-1:0] gpio_out_q;
   logic                      wait_expired, abort, aw_done, w_done;
   logic [CNT_W-1:0]          cnt_inc;

   // The current wait cycle is number cnt_q+1; a handshake landing on the last allowed cycle still wins.
   assign wait_expired = TO_EN && (cnt_q == CNT_LAST);
   assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      rsp_valid_d   = 1'b0;
      rsp_write_d   = rsp_write_q;
      rsp_timeout_d = rsp_timeout_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      cnt_d         = cnt_q;
      abort         = 1'b0;
      aw_done       = !awvalid_q || m_axil_awready;
      w_done        = !wvalid_q || m_axil_wready;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d      = cmd_addr;
               rsp_write_d = cmd_write;
               cnt_d       = '0;
               if (cmd_write) begin
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WRITE;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RADDR;
               end
            end
         end
         ST_WRITE: begin
            if (m_axil_awready) awvalid_d = 1'b0;
            if (m_axil_wready) wvalid_d = 1'b0;
            if (aw_done && w_done) begin
               bready_d = 1'b1;
               cnt_d    = '0;
               state_d  = ST_WRESP;
            end else if (wait_expired) abort = 1'b1;
            else cnt_d = cnt_inc;
         end
         ST_WRESP: begin
            if (m_axil_bvalid) begin
               bready_d      = 1'b0;
               rsp_resp_d    = m_axil_bresp;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = ST_DONE;
            end else if (wait_expired) abort = 1'b1;
            else cnt_d = cnt_inc;
         end
         ST_RADDR: begin
            if (m_axil_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               cnt_d     = '0;
               state_d   = ST_RDATA;
            end else if (wait_expired) abort = 1'b1;
            else cnt_d = cnt_inc;
         end
         ST_RDATA: begin
            if (m_axil_rvalid) begin
               rready_d      = 1'b0;
               rsp_resp_d    = m_axil_rresp;
               rsp_rdata_d   = m_axil_rdata;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = ST_DONE;
            end else if (wait_expired) abort = 1'b1;
            else cnt_d = cnt_inc;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_timeout_d = 1'b1;
         rsp_resp_d    = RESP_SLVERR;
         rsp_rdata_d   = '0;
         rsp_valid_d   = 1'b1;
         state_d       = ST_DONE;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aclk_reset_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= '0;
         cnt_q         <= '0;
         gpio_out_q    <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_write_q   <= rsp_write_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         cnt_q         <= cnt_d;
         if (gpio_wr_en) gpio_out_q <= gpio_wr_data;
      end
   end

   io_sync #(.WIDTH(NUMB_INPUT_IO)) u_gpio_sync (
      .clk_i   (aclk),
      .rst_n_i (aclk_reset_n),
      .d_i     (gpio_in),
      .sync_o  (gpio_in_sync),
      .rise_o  (gpio_in_rise)
   );

   assign cmd_ready      = (state_q == ST_IDLE) && aclk_reset_n;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_write      = rsp_write_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_resp       = rsp_resp_q;
   assign rsp_timeout    = rsp_timeout_q;
   assign m_axil_awaddr  = addr_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = bready_q;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = rready_q;
   assign gpio_out       = gpio_out_q;

endmodule

// File: tb/tb_axil_driver_master.sv
// Bench for axil_driver_master: directed table, random transactions against a latency model, GPIO and reset cases.
module tb_axil_driver_master;

   localparam int T = 8;

   logic        aclk = 1'b0;
   logic        aclk_reset_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [10:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_write, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [10:0] awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        gpio_wr_en;
   logic [1:0]  gpio_wr_data, gpio_out;
   logic [0:0]  gpio_in, gpio_in_sync, gpio_in_rise;

   int n_chk  = 0;
   int n_pass = 0;

   axil_driver_master #(
      .DATA_WIDTH(32), .ADDR_WIDTH(11), .NUMB_INPUT_IO(1), .NUMB_OUTPUT_IO(2), .TIMEOUT_CYCLES(T)
   ) dut (
      .aclk(aclk), .aclk_reset_n(aclk_reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
      .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
      .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
      .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
      .gpio_wr_en(gpio_wr_en), .gpio_wr_data(gpio_wr_data), .gpio_out(gpio_out),
      .gpio_in(gpio_in), .gpio_in_sync(gpio_in_sync), .gpio_in_rise(gpio_in_rise)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic        wr;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          aw_d, w_d, b_d, ar_d, r_d;
      logic [1:0]  bresp, rresp;
      logic [31:0] rdata;
      int          lat;
      logic [1:0]  resp;
      logic [31:0] erdata;
      logic        to;
   } vec_t;

   function automatic vec_t mk(logic wr, logic [10:0] a, logic [31:0] wd, logic [3:0] ws,
                               int awd, int wdd, int bd, int ard, int rdd,
                               logic [1:0] br, logic [1:0] rr, logic [31:0] rdt,
                               int lat, logic [1:0] resp, logic [31:0] erd, logic to);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = wd; v.wstrb = ws;
      v.aw_d = awd; v.w_d = wdd; v.b_d = bd; v.ar_d = ard; v.r_d = rdd;
      v.bresp = br; v.rresp = rr; v.rdata = rdt;
      v.lat = lat; v.resp = resp; v.erdata = erd; v.to = to;
      return v;
   endfunction

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   // Each phase may wait at most T cycles; a phase whose slave delay needs more cycles aborts the transaction.
   task automatic model(inout vec_t v, output int aw_c, output int w_c, output int b_c,
                        output int ar_c, output int r_c, input bit fill);
      int lat, stage;
      logic to;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; to = 1'b0;
      if (v.wr) begin
         aw_c = imin(v.aw_d + 1, T);
         w_c  = imin(v.w_d + 1, T);
         stage = imax(v.aw_d, v.w_d) + 1;
         if (stage > T) begin
            lat = T + 1; to = 1'b1;
         end else begin
            b_c = imin(v.b_d + 1, T);
            if (v.b_d + 1 > T) begin lat = stage + 1 + T; to = 1'b1; end
            else lat = stage + v.b_d + 2;
         end
      end else begin
         ar_c = imin(v.ar_d + 1, T);
         if (v.ar_d + 1 > T) begin
            lat = T + 1; to = 1'b1;
         end else begin
            stage = v.ar_d + 1;
            r_c = imin(v.r_d + 1, T);
            if (v.r_d + 1 > T) begin lat = stage + 1 + T; to = 1'b1; end
            else lat = stage + v.r_d + 2;
         end
      end
      if (fill) begin
         v.lat    = lat;
         v.to     = to;
         v.resp   = to ? 2'b10 : (v.wr ? v.bresp : v.rresp);
         v.erdata = (to || v.wr) ? 32'h0 : v.rdata;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic idle_slave();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
   endtask

   task automatic run_txn(input vec_t vin, input string nm);
      vec_t v;
      int aw_e, w_e, b_e, ar_e, r_e;
      int aw_n, w_n, b_n, ar_n, r_n, r_at, waitc;
      logic bad, extra, rdy_after, g_wr, g_to;
      logic [1:0]  g_resp;
      logic [31:0] g_rdata;
      v = vin;
      model(v, aw_e, w_e, b_e, ar_e, r_e, 1'b0);
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; r_at = 0; waitc = 0;
      bad = 1'b0; extra = 1'b0; rdy_after = 1'b0;
      g_wr = 1'b0; g_to = 1'b0; g_resp = 2'b00; g_rdata = 32'h0;
      while (!cmd_ready && waitc < 50) begin
         @(posedge aclk); #1; waitc++;
      end
      chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
      cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
      @(posedge aclk); #1;
      cmd_valid = 1'b0; cmd_wdata = ~v.wdata; cmd_addr = ~v.addr;
      for (int c = 1; c <= 40; c++) begin
         if (awvalid) begin aw_n++; if (awaddr !== v.addr) bad = 1'b1; end
         if (wvalid) begin w_n++; if (wdata !== v.wdata || wstrb !== v.wstrb) bad = 1'b1; end
         if (arvalid) begin ar_n++; if (araddr !== v.addr) bad = 1'b1; end
         if (bready) b_n++;
         if (rready) r_n++;
         if (r_at == 0 && cmd_ready) bad = 1'b1;
         if (rsp_valid) begin
            if (r_at == 0) begin
               r_at = c; g_wr = rsp_write; g_resp = rsp_resp; g_rdata = rsp_rdata; g_to = rsp_timeout;
            end else extra = 1'b1;
         end else if (r_at != 0) begin
            rdy_after = cmd_ready;
            break;
         end
         awready = awvalid && (aw_n > v.aw_d);
         wready  = wvalid && (w_n > v.w_d);
         arready = arvalid && (ar_n > v.ar_d);
         bvalid  = bready && (b_n > v.b_d);
         bresp   = bvalid ? v.bresp : ~v.bresp;
         rvalid  = rready && (r_n > v.r_d);
         rresp   = rvalid ? v.rresp : ~v.rresp;
         rdata   = rvalid ? v.rdata : ~v.rdata;
         @(posedge aclk); #1;
      end
      idle_slave();
      chk({nm, "_latency"}, 64'(r_at), 64'(v.lat));
      chk({nm, "_rsp_write"}, 64'(g_wr), 64'(v.wr));
      chk({nm, "_rsp_resp"}, 64'(g_resp), 64'(v.resp));
      chk({nm, "_rsp_rdata"}, 64'(g_rdata), 64'(v.erdata));
      chk({nm, "_rsp_timeout"}, 64'(g_to), 64'(v.to));
      chk({nm, "_valid_cycles"}, {24'h0, 8'(aw_n), 8'(w_n), 8'(b_n), 8'(ar_n), 8'(r_n)},
          {24'h0, 8'(aw_e), 8'(w_e), 8'(b_e), 8'(ar_e), 8'(r_e)});
      chk({nm, "_payload_stable"}, 64'(bad), 64'(0));
      chk({nm, "_single_rsp"}, 64'(extra), 64'(0));
      chk({nm, "_ready_after"}, 64'(rdy_after), 64'(1));
   endtask

   vec_t tbl[9];
   vec_t rv;
   int   d0, d1, d2, d3, d4;
   logic seen;

   function automatic int rdly();
      return ($urandom_range(0, 5) == 0) ? int'($urandom_range(7, 12)) : int'($urandom_range(0, 3));
   endfunction

   initial begin
      tbl[0] = mk(1, 11'h010, 32'h0000_00A5, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,  3, 2'b00, 32'h0, 0);
      tbl[1] = mk(0, 11'h000, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 2'b00, 32'hDEAD_BEEF,  5, 2'b00, 32'hDEAD_BEEF, 0);
      tbl[2] = mk(1, 11'h024, 32'h1122_3344, 4'h3, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,  6, 2'b00, 32'h0, 0);
      tbl[3] = mk(0, 11'h100, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 32'h1234_5678,  4, 2'b10, 32'h1234_5678, 0);
      tbl[4] = mk(0, 11'h7FC, 32'h0, 4'h0, 0, 0, 0, 99, 0, 2'b00, 2'b00, 32'h5555_AAAA,  9, 2'b10, 32'h0, 1);
      tbl[5] = mk(1, 11'h004, 32'hFFFF_0000, 4'hC, 0, 0, 99, 0, 0, 2'b00, 2'b00, 32'h0, 10, 2'b10, 32'h0, 1);
      tbl[6] = mk(1, 11'h008, 32'h0BAD_CAFE, 4'h1, 0, 7, 0, 0, 0, 2'b11, 2'b00, 32'h0, 10, 2'b11, 32'h0, 0);
      tbl[7] = mk(1, 11'h00C, 32'h8765_4321, 4'hF, 0, 8, 0, 0, 0, 2'b00, 2'b00, 32'h0,  9, 2'b10, 32'h0, 1);
      tbl[8] = mk(0, 11'h3F0, 32'h0, 4'h0, 0, 0, 0, 7, 7, 2'b00, 2'b01, 32'hCAFE_F00D, 17, 2'b01, 32'hCAFE_F00D, 0);

      aclk_reset_n = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      gpio_wr_en = 1'b0; gpio_wr_data = 2'b00; gpio_in = 1'b0;
      idle_slave();
      repeat (3) @(posedge aclk);
      #1;
      chk("reset_ctrl", 64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                             rsp_timeout, rsp_write, gpio_out, gpio_in_sync, gpio_in_rise}), 64'(0));
      chk("reset_data", {awaddr, araddr, wstrb, rsp_resp, awprot, arprot, 27'h0}, 64'(0));
      chk("reset_wdata_rdata", {wdata, rsp_rdata}, 64'(0));
      aclk_reset_n = 1'b1;
      @(posedge aclk); #1;
      chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));

      for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 30; i++) begin
         rv.wr = 1'($urandom_range(0, 1));
         rv.addr = 11'($urandom); rv.wdata = $urandom; rv.wstrb = 4'($urandom);
         d0 = rdly(); d1 = rdly(); d2 = rdly(); d3 = rdly(); d4 = rdly();
         rv.aw_d = d0; rv.w_d = d1; rv.b_d = d2; rv.ar_d = d3; rv.r_d = d4;
         rv.bresp = 2'($urandom); rv.rresp = 2'($urandom); rv.rdata = $urandom;
         model(rv, d0, d1, d2, d3, d4, 1'b1);
         run_txn(rv, $sformatf("rnd%0d", i));
      end

      // GPIO output register and input synchronizer
      gpio_wr_data = 2'b10; gpio_wr_en = 1'b1;
      @(posedge aclk); #1;
      gpio_wr_en = 1'b0; gpio_wr_data = 2'b01;
      chk("gpio_out_load", 64'(gpio_out), 64'(2'b10));
      @(posedge aclk); #1;
      chk("gpio_out_hold", 64'(gpio_out), 64'(2'b10));
      gpio_in = 1'b1;
      @(posedge aclk); #1;
      chk("gpio_sync_e1", 64'({gpio_in_sync, gpio_in_rise}), 64'(2'b00));
      @(posedge aclk); #1;
      chk("gpio_sync_e2", 64'({gpio_in_sync, gpio_in_rise}), 64'(2'b11));
      @(posedge aclk); #1;
      chk("gpio_sync_e3", 64'({gpio_in_sync, gpio_in_rise}), 64'(2'b10));

      // Reset while waiting for the write response, then a late bvalid
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 11'h050; cmd_wdata = 32'h1357_9BDF; cmd_wstrb = 4'hF;
      @(posedge aclk); #1;
      cmd_valid = 1'b0;
      awready = awvalid; wready = wvalid;
      @(posedge aclk); #1;
      idle_slave();
      chk("wresp_bready", 64'(bready), 64'(1));
      aclk_reset_n = 1'b0;
      @(posedge aclk); #1;
      chk("midreset_ctrl", 64'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                                rsp_timeout, gpio_out, gpio_in_sync, gpio_in_rise}), 64'(0));
      chk("midreset_data", {awaddr, wdata, wstrb, 17'h0}, 64'(0));
      aclk_reset_n = 1'b1;
      bvalid = 1'b1; bresp = 2'b01;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge aclk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      idle_slave();
      chk("late_bvalid_ignored", 64'(seen), 64'(0));
      chk("post_reset_ready", 64'(cmd_ready), 64'(1));

      run_txn(tbl[0], "after_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
